// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one dual_port_ram port among N_REQ requesters, with burst locking
// and read-return tagging. Optional lock timeout is built when ARB_LOCK_TIMEOUT_EN is defined.
module mem_port_arbiter #(
  parameter int N_REQ      = 3,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64,
  parameter int RD_LAT     = 1,
  parameter int LOCK_MAX   = 64
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            lock,
  input  logic [N_REQ-1:0]            wr_en,
  input  logic [N_REQ*ADDR_WIDTH-1:0] addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]            gnt,
  output logic [N_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]       rdata,
  output logic                        ram_we,
  output logic [ADDR_WIDTH-1:0]       ram_addr,
  output logic [DATA_WIDTH-1:0]       ram_din,
  input  logic [DATA_WIDTH-1:0]       ram_dout,
  output logic                        lock_broken,
  output logic                        dbg_state_o
);

  localparam int IW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || RD_LAT < 1 || RD_LAT > 4 || LOCK_MAX < 1) begin : g_param_check
    $error("mem_port_arbiter: parameter out of range");
  end

  typedef enum logic {ST_FREE, ST_LOCKED} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic            free_found;
  logic [IW-1:0]   free_idx;
  logic            owner_hold;
  logic            gnt_any;
  logic [IW-1:0]   gnt_idx;
  logic            timeout;
  logic [RD_LAT-1:0][N_REQ:0] tag_q;
  logic [N_REQ:0]  tag_push;

  assign dbg_state_o = (state_q == ST_LOCKED);

  // Round-robin search begins one past the last granted index and wraps.
  always_comb begin : rr_search
    int idx;
    idx        = 0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!free_found && req[IW'(idx)]) begin
        free_found = 1'b1;
        free_idx   = IW'(idx);
      end
    end
  end

  always_comb begin
    owner_hold = (state_q == ST_LOCKED) && req[owner_q];
    gnt_idx    = owner_hold ? owner_q : free_idx;
    gnt_any    = rstn && (owner_hold || free_found);
    gnt        = gnt_any ? (N_REQ'(1) << gnt_idx) : '0;
  end

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        ram_we   = wr_en[i];
        ram_addr = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        ram_din  = wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A locked owner that drops req frees the port in the same cycle, so the
  // free-search winner may itself lock and become the new owner.
  always_comb begin
    state_d = ST_FREE;
    owner_d = owner_q;
    last_d  = gnt_any ? gnt_idx : last_q;
    if (owner_hold) begin
      if (lock[owner_q] && !timeout) state_d = ST_LOCKED;
    end else if (gnt_any && lock[gnt_idx]) begin
      state_d = ST_LOCKED;
      owner_d = gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_FREE;
      last_q  <= IW'(N_REQ - 1);
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
    end
  end

`ifdef ARB_LOCK_TIMEOUT_EN
  localparam int CW = $clog2(LOCK_MAX + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          locked_grant;
  logic          others_req;

  always_comb begin
    locked_grant = gnt_any && owner_hold && lock[owner_q];
    others_req   = |(req & ~(N_REQ'(1) << owner_q));
    timeout      = locked_grant && others_req && (cnt_q == CW'(LOCK_MAX - 1));
    cnt_d        = '0;
    if (locked_grant && !timeout) cnt_d = others_req ? cnt_q + CW'(1) : cnt_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign lock_broken = timeout;
`else
  assign timeout     = 1'b0;
  assign lock_broken = 1'b0;
`endif

  // Tag entry is {valid, one-hot owner}; it reaches the tail as RAM data arrives.
  always_comb begin
    tag_push = '0;
    if (gnt_any && !wr_en[gnt_idx]) tag_push = {1'b1, gnt};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_q <= '0;
    end else begin
      tag_q[0] <= tag_push;
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign rvalid = tag_q[RD_LAT-1][N_REQ] ? tag_q[RD_LAT-1][N_REQ-1:0] : '0;
  assign rdata  = ram_dout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic against a queue-based model.
module tb_mem_port_arbiter;
  localparam int N  = 3;
  localparam int AW = 12;
  localparam int DW = 16;
  localparam int RL = 2;
  localparam int LM = 8;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    req, lock, wr_en;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt, rvalid;
  logic [DW-1:0]   rdata, ram_din, ram_dout;
  logic            ram_we, lock_broken, dbg_state;
  logic [AW-1:0]   ram_addr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(RL), .LOCK_MAX(LM)) dut (
    .clk(clk), .rstn(rstn), .req(req), .lock(lock), .wr_en(wr_en), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout), .lock_broken(lock_broken), .dbg_state_o(dbg_state)
  );

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    case (a)
      12'h010: return 16'h000A;
      12'h020: return 16'h000B;
      default: return {a[3:0], a} ^ 16'h3C3C;
    endcase
  endfunction

  // RAM port behaviour with RL cycles of read latency
  logic [DW-1:0] mem [4096];
  bit            written [4096];
  logic [DW-1:0] rd_pipe [RL];

  always @(posedge clk) begin
    rd_pipe[0] <= written[ram_addr] ? mem[ram_addr] : init_val(ram_addr);
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (ram_we) begin
      mem[ram_addr]     <= ram_din;
      written[ram_addr] <= 1'b1;
    end
  end
  assign ram_dout = rd_pipe[RL-1];

  // Reference model
  typedef struct {int due; int id; logic [DW-1:0] data;} rd_t;
  rd_t           pend[$];
  logic [DW-1:0] mmem [int];
  bit            m_locked, n_locked;
  int            m_owner, n_owner, m_last, n_last, m_cnt, n_cnt;
  int            e_idx, cyc;
  logic [N-1:0]  e_gnt, e_rv;
  logic          e_we, e_lb;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_din, e_rd;

  function automatic logic [N-1:0] onehot(input int i);
    return N'(1) << i;
  endfunction

  function automatic logic [DW-1:0] mread(input logic [AW-1:0] a);
    return mmem.exists(int'(a)) ? mmem[int'(a)] : init_val(a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clr();
    req = '0; lock = '0; wr_en = '0; addr = '0; wdata = '0;
  endtask

  task automatic drv(input int i, input bit r, input bit l, input bit w,
                     input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = r; lock[i] = l; wr_en[i] = w;
    addr[i*AW +: AW] = a;
    wdata[i*DW +: DW] = d;
  endtask

  task automatic eval();
    bit hold, lk, others;
    #1;
    e_idx = -1; e_gnt = '0; e_we = 1'b0; e_addr = '0; e_din = '0;
    e_rv = '0; e_rd = '0; e_lb = 1'b0;
    n_locked = 1'b0; n_owner = m_owner; n_last = m_last; n_cnt = 0;
    if (rstn) begin
      hold = m_locked && req[m_owner];
      if (hold) e_idx = m_owner;
      else
        for (int k = 1; k <= N; k++) begin
          int j;
          j = (m_last + k) % N;
          if (e_idx < 0 && req[j]) e_idx = j;
        end
      if (e_idx >= 0) begin
        e_gnt  = onehot(e_idx);
        e_we   = wr_en[e_idx];
        e_addr = addr[e_idx*AW +: AW];
        e_din  = wdata[e_idx*DW +: DW];
        n_last = e_idx;
      end
      if (pend.size() > 0 && pend[0].due == cyc) begin
        e_rv = onehot(pend[0].id);
        e_rd = pend[0].data;
      end
      if (hold) begin
        lk     = lock[m_owner];
        others = (req & ~onehot(m_owner)) != '0;
        n_cnt  = m_cnt;
`ifdef ARB_LOCK_TIMEOUT_EN
        if (lk && others) begin
          n_cnt = m_cnt + 1;
          if (n_cnt == LM) e_lb = 1'b1;
        end
`endif
        n_locked = lk && !e_lb;
        if (!n_locked) n_cnt = 0;
      end else begin
        n_locked = (e_idx >= 0) && lock[e_idx];
        n_owner  = e_idx;
        n_cnt    = 0;
      end
    end
    chk("gnt", gnt, e_gnt);
    chk("ram_we", ram_we, e_we);
    chk("ram_addr", ram_addr, e_addr);
    chk("ram_din", ram_din, e_din);
    chk("rvalid", rvalid, e_rv);
    if (e_rv != '0) chk("rdata", rdata, e_rd);
    chk("lock_broken", lock_broken, e_lb);
    chk("locked_state", dbg_state, rstn && m_locked);
  endtask

  task automatic tick();
    rd_t r;
    @(posedge clk);
    if (!rstn) begin
      pend.delete();
      m_locked = 1'b0; m_owner = 0; m_last = N - 1; m_cnt = 0;
    end else begin
      if (e_rv != '0) void'(pend.pop_front());
      if (e_idx >= 0) begin
        if (e_we) mmem[int'(e_addr)] = e_din;
        else begin
          r.due = cyc + RL; r.id = e_idx; r.data = mread(e_addr);
          pend.push_back(r);
        end
      end
      m_locked = n_locked; m_owner = n_owner; m_last = n_last; m_cnt = n_cnt;
      cyc++;
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [N-1:0] rr_exp [6];

  initial begin
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    rstn = 1'b0;
    clr();
    cyc = 0; m_locked = 1'b0; m_owner = 0; m_last = N - 1; m_cnt = 0;
    repeat (2) @(negedge clk);
    eval();
    chk("reset_rvalid", rvalid, 3'b000);
    tick();
    rstn = 1'b1;

    // Round-robin with all three reading
    clr();
    for (int i = 0; i < N; i++) drv(i, 1, 0, 0, AW'(i + 1), '0);
    for (int s = 0; s < 6; s++) begin
      eval();
      chk("rr_seq", gnt, rr_exp[s]);
      tick();
    end
    clr();
    repeat (2) begin eval(); tick(); end

    // Back-to-back reads return in order
    drv(1, 1, 0, 0, 12'h010, '0); eval(); tick();
    clr(); drv(2, 1, 0, 0, 12'h020, '0); eval(); tick();
    clr(); eval();
    chk("rd_ret_rv0", rvalid, 3'b010);
    chk("rd_ret_d0", rdata, 16'h000A);
    tick();
    eval();
    chk("rd_ret_rv1", rvalid, 3'b100);
    chk("rd_ret_d1", rdata, 16'h000B);
    tick();

    // Write then read of the same address in consecutive cycles
    clr(); drv(0, 1, 0, 1, 12'h007, 16'hBEEF); eval(); tick();
    clr(); drv(1, 1, 0, 0, 12'h007, '0); eval(); tick();
    clr(); eval(); tick();
    eval();
    chk("raw_rvalid", rvalid, 3'b010);
    chk("raw_rdata", rdata, 16'hBEEF);
    tick();

    // Locked 4-word write burst by req0 with req1 waiting
    for (int b = 0; b < 4; b++) begin
      clr();
      drv(0, 1, 1, 1, AW'(256 + b), DW'(16'hC000 + b));
      drv(1, 1, 0, 0, 12'h005, '0);
      eval();
      chk("burst_gnt", gnt, 3'b001);
      chk("burst_we", ram_we, 1'b1);
      tick();
    end
    clr(); drv(1, 1, 0, 0, 12'h005, '0); eval();
    chk("burst_after", gnt, 3'b010);
    tick();
    clr(); drv(2, 1, 0, 0, 12'h103, '0); eval(); tick();
    clr();
    repeat (3) begin eval(); tick(); end

    // Lock held indefinitely by req0 while req2 waits
    drv(0, 1, 1, 0, 12'h030, '0); eval();
    chk("lock_first", gnt, 3'b001);
    tick();
`ifdef ARB_LOCK_TIMEOUT_EN
    for (int c = 1; c <= 9; c++) begin
      clr(); drv(0, 1, 1, 0, 12'h030, '0); drv(2, 1, 0, 0, 12'h031, '0);
      eval();
      if (c == 8) chk("lock_broken_pulse", lock_broken, 1'b1);
      if (c == 9) chk("break_gnt", gnt, 3'b100);
      tick();
    end
`else
    for (int c = 1; c <= 20; c++) begin
      clr(); drv(0, 1, 1, 0, 12'h030, '0); drv(2, 1, 0, 0, 12'h031, '0);
      eval();
      chk("lock_hold", gnt, 3'b001);
      tick();
    end
`endif
    clr();
    repeat (3) begin eval(); tick(); end

    // Reset in the middle of a locked burst with reads in flight
    drv(2, 1, 0, 0, 12'h020, '0); eval(); tick();
    clr(); drv(0, 1, 1, 0, 12'h010, '0); eval(); tick();
    clr(); drv(0, 1, 1, 1, 12'h011, 16'h1111); drv(1, 1, 0, 0, 12'h012, '0);
    rstn = 1'b0;
    eval();
    chk("rst_gnt", gnt, 3'b000);
    chk("rst_rvalid", rvalid, 3'b000);
    chk("rst_we", ram_we, 1'b0);
    tick();
    rstn = 1'b1;
    clr();
    for (int i = 0; i < N; i++) drv(i, 1, 0, 0, AW'(i + 8), '0);
    eval();
    chk("post_rst_gnt", gnt, 3'b001);
    tick();
    clr();
    repeat (4) begin eval(); tick(); end

    // Random traffic over a small address window
    repeat (400) begin
      for (int i = 0; i < N; i++)
        drv(i, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
            AW'($urandom_range(0, 15)), DW'($urandom));
      eval();
      tick();
    end
    clr();
    repeat (4) begin eval(); tick(); end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
